// File: rtl/instr_stream_loader_if.sv
// ----------------------------------------------------------------------------
// instr_stream_loader_if
//   Signal bundle between the host byte link, the loader and the instruction
//   memory write port.
//
//   master : host side. Drives clear, byte_valid and byte_data. Observes
//            byte_ready, the memory write port and the status outputs.
//   slave  : loader side. This is the mirror of master.
//
//   Signals
//     clear        synchronous return to IDLE
//     byte_valid   byte_data is valid
//     byte_data    stream byte, little-endian within a word
//     byte_ready   loader accepts a byte this cycle
//     imem_we      one-cycle write strobe per accepted word
//     imem_addr    write word address
//     imem_wdata   write data
//     loading      high while a program is being loaded
//     done         high after a close word was written
//     error        high after a rejected word
//     word_count   words written since start, including close
// ----------------------------------------------------------------------------
interface instr_stream_loader_if #(
   parameter int ADDR_W = 10
);
   logic              clear;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              loading;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   modport master (
      output clear, byte_valid, byte_data,
      input  byte_ready, imem_we, imem_addr, imem_wdata,
             loading, done, error, word_count
   );

   modport slave (
      input  clear, byte_valid, byte_data,
      output byte_ready, imem_we, imem_addr, imem_wdata,
             loading, done, error, word_count
   );
endinterface

// File: rtl/instr_stream_loader.sv
// ----------------------------------------------------------------------------
// instr_stream_loader
//   Byte-stream instruction loader. Bytes arrive over a valid/ready link. They
//   are packed little-endian into 32-bit words. Each completed word is
//   evaluated one cycle later against the ISA opcode set (instr[31:26]). A
//   start word opens a program. Legal words are then written to instruction
//   memory at sequential addresses until a close word, which is also written.
//   Any illegal word, a second start, or overflow past DEPTH parks the loader
//   in ERROR.
//
//   Ports
//     clk   system clock
//     rst   asynchronous, active-high reset
//     bus   instr_stream_loader_if.slave. It carries the byte link, the clear
//           input, the memory write port and the status outputs.
//
//   Parameters
//     ADDR_W  instruction memory word-address width
//     DEPTH   number of writable words (DEPTH <= 2**ADDR_W)
// ----------------------------------------------------------------------------
module instr_stream_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   instr_stream_loader_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DONE  = 2'd2,
      S_ERROR = 2'd3
   } state_t;

   localparam logic [5:0] OP_START = 6'b110010;
   localparam logic [5:0] OP_CLOSE = 6'b110001;

   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

   // The ISA opcode set, start and close included.
   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         6'b000000, 6'b010000, 6'b000100, 6'b001100,
         6'b010001, 6'b010010, 6'b010101, 6'b010110,
         6'b011101, 6'b011110, 6'b100000, 6'b100001,
         6'b100010, 6'b111111, OP_START, OP_CLOSE: ok = 1'b1;
         default:                                  ok = 1'b0;
      endcase
      return ok;
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;       // next byte lane within the word
   logic [31:0]     word_q, word_d;     // word under assembly / under evaluation
   logic            pend_q, pend_d;     // a full word waits for evaluation
   logic [ADDR_W:0] count_q, count_d;   // words written since start

   logic            ready;
   logic            accept;
   logic            we;
   logic [5:0]      op;

   assign op = word_q[31:26];

   // Bytes are refused while a word is pending. This gives exactly one
   // bubble per word and keeps word_q stable during evaluation. rst gates
   // ready directly so that the link sees 0 for the whole reset pulse.
   assign ready  = ~rst & ~pend_q & ~bus.clear &
                   ((state_q == S_IDLE) | (state_q == S_LOAD));
   assign accept = bus.byte_valid & ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      pend_d  = 1'b0;            // a pending word is consumed in its one EVAL cycle
      count_d = count_q;
      we      = 1'b0;

      if (bus.clear) begin
         // clear overrides both a pending word and an offered byte.
         state_d = S_IDLE;
         idx_d   = 2'd0;
         count_d = '0;
      end else begin
         if (accept) begin
            case (idx_q)
               2'd0:    word_d[7:0]   = bus.byte_data;
               2'd1:    word_d[15:8]  = bus.byte_data;
               2'd2:    word_d[23:16] = bus.byte_data;
               default: word_d[31:24] = bus.byte_data;
            endcase
            idx_d = idx_q + 2'd1;          // wraps to 0 after lane 3
            if (idx_q == 2'd3) pend_d = 1'b1;
         end

         if (pend_q) begin
            case (state_q)
               S_IDLE: begin
                  // Everything before a start word is discarded.
                  if (op == OP_START) begin
                     state_d = S_LOAD;
                     count_d = '0;
                  end
               end
               S_LOAD: begin
                  if (op_legal(op) && (op != OP_START) && (count_q < DEPTH_W)) begin
                     we      = 1'b1;
                     count_d = count_q + ONE_W;
                     if (op == OP_CLOSE) state_d = S_DONE;
                  end else begin
                     state_d = S_ERROR;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= 2'd0;
         word_q  <= '0;
         pend_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         pend_q  <= pend_d;
         count_q <= count_d;
      end
   end

   // The write address is the pre-increment word count. It holds for the
   // write cycle and advances after it. Write data reads as zero when no
   // write is taking place.
   assign bus.byte_ready = ready;
   assign bus.imem_we    = we;
   assign bus.imem_addr  = count_q[ADDR_W-1:0];
   assign bus.imem_wdata = we ? word_q : 32'h0;
   assign bus.loading    = (state_q == S_LOAD);
   assign bus.done       = (state_q == S_DONE);
   assign bus.error      = (state_q == S_ERROR);
   assign bus.word_count = count_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_stream_loader
//   Randomised byte-stream stimulus with directed scenarios up front. A
//   behavioural program model predicts memory writes into a scoreboard queue.
//   A monitor thread pops from that queue and compares on every imem_we.
//   Status outputs are checked after each word's evaluation cycle.
// ----------------------------------------------------------------------------
module tb_instr_stream_loader;
   localparam int ADDR_W = 3;
   localparam int DEPTH  = 4;

   localparam bit [5:0] START = 6'b110010;
   localparam bit [5:0] CLOSE = 6'b110001;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   instr_stream_loader_if #(.ADDR_W(ADDR_W)) bus();

   instr_stream_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   // Program model: 0 idle, 1 loading, 2 done, 3 error.
   int  m_mode  = 0;
   int  m_count = 0;

   bit [5:0] isa_ops[16] = '{6'b000000, 6'b010000, 6'b000100, 6'b001100,
                             6'b010001, 6'b010010, 6'b010101, 6'b010110,
                             6'b011101, 6'b011110, 6'b100000, 6'b100001,
                             6'b100010, 6'b111111, START, CLOSE};

   function automatic bit in_isa(input bit [5:0] op);
      foreach (isa_ops[i]) if (isa_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // kind: 0 ordinary legal, 1 illegal, 2 close, 3 start
   function automatic bit [31:0] rand_word(input int kind);
      bit [5:0] op;
      case (kind)
         0:       op = isa_ops[$urandom_range(0, 13)];
         2:       op = CLOSE;
         3:       op = START;
         default: begin
            op = 6'($urandom);
            while (in_isa(op)) op = 6'($urandom);
         end
      endcase
      return {op, 26'($urandom)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = 0;
      m_count = 0;
   endtask

   // Program rules. A write is predicted only for an in-ISA, non-start word
   // while loading with room left.
   task automatic model_eval(input bit [31:0] w, output bit wr);
      bit [5:0] op;
      op = w[31:26];
      wr = 1'b0;
      if (m_mode == 0) begin
         if (op == START) begin m_mode = 1; m_count = 0; end
      end else if (m_mode == 1) begin
         if (in_isa(op) && op != START && m_count < DEPTH) begin
            exp_q.push_back({m_count[ADDR_W-1:0], w});
            m_count++;
            wr = 1'b1;
            if (op == CLOSE) m_mode = 2;
         end else begin
            m_mode = 3;
         end
      end
   endtask

   task automatic check_status(input string nm);
      chk({nm, "_loading"}, 64'(bus.loading),    64'(m_mode == 1));
      chk({nm, "_done"},    64'(bus.done),       64'(m_mode == 2));
      chk({nm, "_error"},   64'(bus.error),      64'(m_mode == 3));
      chk({nm, "_count"},   64'(bus.word_count), 64'(m_count));
      chk({nm, "_ready"},   64'(bus.byte_ready), 64'(m_mode < 2));
      if (m_mode == 1) chk({nm, "_addr"}, 64'(bus.imem_addr), 64'(m_count % (1 << ADDR_W)));
   endtask

   // Offers a byte from just after a posedge. It returns just after the
   // accepting posedge, or reports a timeout.
   task automatic send_byte(input bit [7:0] b, output bit ok);
      bit acc;
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      ok = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         acc = bus.byte_ready;
         @(posedge clk);
         #1;
         if (acc) begin ok = 1'b1; break; end
      end
      if (!ok) chk("byte_accept_timeout", 64'(0), 64'(1));
   endtask

   task automatic idle_gap(input int gap_max);
      int g;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (g > 0) begin
         bus.byte_valid = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
      end
   endtask

   // Sends one word. acc_cyc is the cycle in which its last byte was taken.
   // When clr_eval is set, clear is raised during the evaluation cycle.
   task automatic send_word(input bit [31:0] w, input int gap_max, input bit clr_eval,
                            output int acc_cyc);
      bit ok;
      bit wr;
      acc_cyc = -1;
      for (int k = 0; k < 4; k++) begin
         idle_gap(gap_max);
         send_byte(w[8*k +: 8], ok);
         if (!ok) return;
      end
      acc_cyc = cyc;
      // We are now inside the evaluation cycle.
      if (clr_eval) begin
         bus.clear = 1'b1;
         #1;
         chk("clear_beats_pending_we", 64'(bus.imem_we), 64'(0));
         @(posedge clk); #1;
         bus.clear = 1'b0;
         model_reset();
         #1;
         check_status("clear_eval");
         return;
      end
      model_eval(w, wr);
      chk("eval_bubble_ready", 64'(bus.byte_ready), 64'(0));
      chk("eval_we",           64'(bus.imem_we),    64'(wr));
      @(posedge clk); #1;
      chk("write_missing", 64'(exp_q.size()), 64'(0));
      check_status("post_eval");
   endtask

   task automatic send_partial(input bit [31:0] w, input int n);
      bit ok;
      for (int k = 0; k < n; k++) begin
         send_byte(w[8*k +: 8], ok);
         if (!ok) return;
      end
      bus.byte_valid = 1'b0;
   endtask

   // clear while a byte is offered. The byte must not be taken.
   task automatic do_clear();
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      bus.clear      = 1'b1;
      #1;
      chk("clear_blocks_ready", 64'(bus.byte_ready), 64'(0));
      chk("clear_no_we",        64'(bus.imem_we),    64'(0));
      @(posedge clk); #1;
      bus.clear      = 1'b0;
      bus.byte_valid = 1'b0;
      model_reset();
      #1;
      check_status("after_clear");
   endtask

   task automatic stall_check();
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom);
      repeat (3) begin
         @(negedge clk);
         chk("stall_ready", 64'(bus.byte_ready), 64'(0));
         @(posedge clk); #1;
      end
      bus.byte_valid = 1'b0;
      check_status("stall");
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_ready"},   64'(bus.byte_ready), 64'(0));
      chk({nm, "_we"},      64'(bus.imem_we),    64'(0));
      chk({nm, "_addr"},    64'(bus.imem_addr),  64'(0));
      chk({nm, "_wdata"},   64'(bus.imem_wdata), 64'(0));
      chk({nm, "_count"},   64'(bus.word_count), 64'(0));
      chk({nm, "_loading"}, 64'(bus.loading),    64'(0));
      chk({nm, "_done"},    64'(bus.done),       64'(0));
      chk({nm, "_error"},   64'(bus.error),      64'(0));
   endtask

   task automatic monitor();
      wr_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus.imem_we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 64'(bus.imem_addr),  64'(e.addr));
               chk("wr_data", 64'(bus.imem_wdata), 64'(e.data));
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int ac, ac_prev, r, nw;
      bit ok;
      fork monitor(); join_none

      rst = 1'b1;
      bus.clear = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_data = 8'h00;
      #3;
      check_reset_outputs("reset");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check_status("after_reset");

      // Basic load
      send_word(32'hC8000000, 0, 1'b0, ac);
      send_word(32'h40010005, 0, 1'b0, ac);
      send_word(32'hC4000000, 0, 1'b0, ac);
      chk("basic_done",  64'(bus.done),       64'(1));
      chk("basic_count", 64'(bus.word_count), 64'(2));
      do_clear();

      // Pre-start filtering
      send_word(32'h00000020, 1, 1'b0, ac);
      chk("prestart_not_loading", 64'(bus.loading), 64'(0));
      send_word(32'hC8000000, 1, 1'b0, ac);
      chk("prestart_loading", 64'(bus.loading),   64'(1));
      chk("prestart_addr0",   64'(bus.imem_addr), 64'(0));

      // Illegal opcode in LOAD
      send_word(32'h0C000000, 1, 1'b0, ac);
      chk("illegal_error", 64'(bus.error),      64'(1));
      chk("illegal_ready", 64'(bus.byte_ready), 64'(0));
      stall_check();
      do_clear();
      chk("illegal_clear_ready", 64'(bus.byte_ready), 64'(1));

      // Capacity: four writes fill DEPTH, the close then overflows
      send_word(32'hC8000000, 0, 1'b0, ac);
      for (int i = 0; i < 4; i++) send_word(32'h40010005 + i, 1, 1'b0, ac);
      send_word(32'hC4000000, 0, 1'b0, ac);
      chk("cap_error", 64'(bus.error),      64'(1));
      chk("cap_count", 64'(bus.word_count), 64'(4));
      do_clear();

      // Back-to-back: valid held high, one word per five cycles
      send_word(32'hC8000000, 0, 1'b0, ac_prev);
      for (int i = 0; i < 3; i++) begin
         send_word(rand_word(0), 0, 1'b0, ac);
         chk("throughput_5cyc", 64'(ac - ac_prev), 64'(5));
         ac_prev = ac;
      end
      // Long gaps mid-word keep the partial word.
      send_word(rand_word(0), 6, 1'b0, ac);
      send_word(rand_word(2), 4, 1'b0, ac);
      do_clear();

      // Reset in the middle of a word while loading
      send_word(32'hC8000000, 0, 1'b0, ac);
      send_word(32'h40010005, 0, 1'b0, ac);
      send_partial(32'h40020006, 2);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      model_reset();
      check_status("midrst_after");
      send_word(32'hC8000000, 0, 1'b0, ac);
      send_word(32'h40030007, 0, 1'b0, ac);   // must land at addr 0
      do_clear();

      // Clear with a partial word held, then start over
      send_word(32'hC8000000, 0, 1'b0, ac);
      send_partial(32'h40040008, 3);
      do_clear();
      send_word(32'hC8000000, 0, 1'b0, ac);
      send_word(32'h40050009, 0, 1'b0, ac);
      do_clear();

      // Random programs
      for (int p = 0; p < 30; p++) begin
         int gm;
         gm = $urandom_range(0, 3);
         repeat ($urandom_range(0, 2)) send_word(rand_word($urandom_range(0, 2)), gm, 1'b0, ac);
         send_word(rand_word(3), gm, 1'b0, ac);
         nw = $urandom_range(0, 6);
         for (int i = 0; i < nw && m_mode == 1; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      send_word(rand_word(1), gm, 1'b0, ac);
            else if (r == 1) send_word(rand_word(3), gm, 1'b0, ac);
            else if (r == 2) send_word(rand_word(0), gm, 1'b1, ac);
            else             send_word(rand_word(0), gm, 1'b0, ac);
         end
         if (m_mode == 1 && $urandom_range(0, 3) != 0) send_word(rand_word(2), gm, 1'b0, ac);
         if (m_mode >= 2) stall_check();
         if (m_mode < 2 && $urandom_range(0, 2) == 0) send_partial(rand_word(0), $urandom_range(1, 3));
         do_clear();
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
